stream_demux: RTL and testbench
===============================

# stream_demux

Registered 1-to-N packet demultiplexer for valid/ready streams, the parametrised successor to the team's combinational 1:4 demux. It sits between a single upstream producer and N downstream consumers. It locks a destination channel at the first beat of each packet and holds it until the last beat. Packets addressed to a nonexistent channel are discarded and counted. A single output register stage gives full throughput and fixed 1-cycle latency.

## Interface
- WIDTH, default 8: data beat width in bits.
- N_OUT, default 4: number of output channels, range 2..16.
- SEL_W, default 2: select width. Must be ≥ clog2(N_OUT). Select codes ≥ N_OUT are out of range.
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- s_data, input, WIDTH: input beat data.
- s_sel, input, SEL_W: destination channel. Sampled only on the first beat of a packet.
- s_last, input, 1: marks the final beat of a packet.
- s_valid, input, 1: input beat valid.
- s_ready, output, 1: input beat accepted when s_valid && s_ready.
- m_data, output, N_OUT*WIDTH: lane k occupies bits [k*WIDTH +: WIDTH].
- m_last, output, N_OUT: per-channel last flag.
- m_valid, output, N_OUT: per-channel valid. At most one bit is set at any time.
- m_ready, input, N_OUT: per-channel ready.
- drop_cnt, output, 8: count of dropped packets, saturating at 255.

## Operation
- Input state machine states:
  - IDLE: expecting the first beat of a packet.
  - ROUTE: mid-packet, locked to channel dst.
  - DROP: mid-packet, discarding.
- Output register: holds one beat, consisting of data, last, a 1-bit full flag, and the destination index out_dst. The entry carries its own destination, independent of dst.
- Register "drains" when: full && m_ready[out_dst].
- Register "can load" when: !full || drain.
- s_ready:
  - In IDLE and ROUTE: equals "can load".
  - In DROP: constant 1.
- IDLE, on an accepted beat with s_sel < N_OUT:
  - dst ← s_sel; beat loads the register with out_dst = s_sel.
  - Next state: ROUTE if !s_last, otherwise stay in IDLE.
- IDLE, on an accepted beat with s_sel ≥ N_OUT:
  - Beat is discarded and drop_cnt increments (saturating).
  - Next state: DROP if !s_last, otherwise stay in IDLE.
- ROUTE:
  - Each accepted beat loads the register with out_dst = dst.
  - s_sel is ignored.
  - Beat with s_last → IDLE.
- DROP:
  - Every beat is accepted and discarded; drop_cnt does not change.
  - Beat with s_last → IDLE.
- Outputs:
  - m_valid[k] = full && (out_dst == k).
  - m_data lane k and m_last[k] show the registered beat when m_valid[k] is 1, otherwise 0. Unselected lanes are always zero.
- Simultaneous drain and load: the register takes the new beat and full stays 1. This gives back-to-back beats with no bubble, including across a packet boundary to a different channel.
- Drain without load: full ← 0.
- A downstream stall stalls only the held beat. There is no reordering and no buffering beyond one beat.

## Timing
- Reset (rst = 1 at a clock edge) sets:
  - state = IDLE, full = 0, dst = 0, out_dst = 0, drop_cnt = 0.
  - All m_valid = 0, m_data = 0, m_last = 0.
  - s_ready = 1 in the cycle after reset.
- Reset mid-packet abandons the packet immediately. A beat held in the register is lost.
- Latency: a beat accepted at edge t appears on m_* during cycle t+1.
- Throughput: 1 beat per clock while the consumer holds m_ready high.
- s_ready depends combinationally on m_ready[out_dst]. No other combinational input-to-output path exists.
- m_valid, m_data and m_last are driven from registers only.
- Handshake rules:
  - Upstream must hold s_data, s_sel, s_last and s_valid stable until accepted.
  - Once m_valid[k] rises it stays high with stable data until m_ready[k].
- A single-beat packet (s_last on its first beat) stays in IDLE, whether routed or dropped.
- drop_cnt holds at 255 and never wraps.

## Test plan
- Reset: drive rst=1 for 2 cycles mid-packet with full=1, then rst=0 → all m_valid=0, drop_cnt=0, s_ready=1. The next beat is treated as a first beat, and its s_sel is honoured.
- Routing: send 3-beat packets (0x11/0x12/0x13 to ch 2, then 0x21/0x22 to ch 0) back-to-back with all m_ready=1 → ch2 sees 0x11,0x12,0x13 with last on 0x13 in cycles t+1..t+3. ch0 sees 0x21,0x22 in the next two cycles with no bubble. s_sel changes mid-packet are ignored.
- Backpressure: packet to ch1, m_ready[1]=0 for 4 cycles → m_valid[1] holds with the beat stable, s_ready=0, and no other m_valid rises. Set m_ready[1]=1 → remaining beats flow at 1 per clock.
- Drop: with N_OUT=3, SEL_W=2, send a 4-beat packet with s_sel=3 → s_ready=1 on all beats, no m_valid, drop_cnt 0→1. A following packet to ch1 routes correctly.
- Saturation: send 260 single-beat packets with out-of-range s_sel → drop_cnt reads 255 and stays 255.
- Lane isolation: WIDTH=16, N_OUT=8, beat 0xBEEF to ch 7 → m_data[127:112]=0xBEEF and all other lanes 0.

Source files
------------

// File: rtl/stream_demux_if.sv
// Valid/ready bundle for the 1-to-N stream demultiplexer.
// master is the upstream/downstream environment, slave is the demux.
interface stream_demux_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2
);
  logic [WIDTH-1:0]       s_data;
  logic [SEL_W-1:0]       s_sel;
  logic                   s_last;
  logic                   s_valid;
  logic                   s_ready;
  logic [N_OUT*WIDTH-1:0] m_data;
  logic [N_OUT-1:0]       m_last;
  logic [N_OUT-1:0]       m_valid;
  logic [N_OUT-1:0]       m_ready;
  logic [7:0]             drop_cnt;

  modport master (
    output s_data, s_sel, s_last, s_valid,
    input  s_ready,
    input  m_data, m_last, m_valid,
    output m_ready,
    input  drop_cnt
  );

  modport slave (
    input  s_data, s_sel, s_last, s_valid,
    output s_ready,
    output m_data, m_last, m_valid,
    input  m_ready,
    output drop_cnt
  );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-N packet demux: locks a channel per packet,
// drops and counts packets addressed to nonexistent channels.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  stream_demux_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    DROP
  } state_t;

  localparam logic [SEL_W:0] NOUT_L = (SEL_W+1)'(N_OUT);

  state_t           state, state_nx;
  logic [SEL_W-1:0] dst, dst_nx;
  logic [SEL_W-1:0] out_dst, load_dst;
  logic [WIDTH-1:0] data_q;
  logic             last_q;
  logic             full;
  logic [7:0]       drop_q;

  logic drain, can_load, in_range;
  logic load, drop_hit, s_ready_c;

  assign drain    = full && bus.m_ready[out_dst];
  assign can_load = !full || drain;
  assign in_range = {1'b0, bus.s_sel} < NOUT_L;

  always_comb begin
    state_nx  = state;
    dst_nx    = dst;
    load_dst  = dst;
    load      = 1'b0;
    drop_hit  = 1'b0;
    s_ready_c = can_load;
    unique case (state)
      IDLE: begin
        if (bus.s_valid && can_load) begin
          if (in_range) begin
            load     = 1'b1;
            load_dst = bus.s_sel;
            dst_nx   = bus.s_sel;
            if (!bus.s_last) state_nx = ROUTE;
          end else begin
            drop_hit = 1'b1;
            if (!bus.s_last) state_nx = DROP;
          end
        end
      end
      ROUTE: begin
        if (bus.s_valid && can_load) begin
          load = 1'b1;
          if (bus.s_last) state_nx = IDLE;
        end
      end
      DROP: begin
        s_ready_c = 1'b1;
        if (bus.s_valid && bus.s_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dst     <= '0;
      out_dst <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      full    <= 1'b0;
      drop_q  <= '0;
    end else begin
      state <= state_nx;
      dst   <= dst_nx;
      // a load during a drain replaces the beat, keeping full set
      if (load) begin
        data_q  <= bus.s_data;
        last_q  <= bus.s_last;
        out_dst <= load_dst;
        full    <= 1'b1;
      end else if (drain) begin
        full <= 1'b0;
      end
      if (drop_hit && drop_q != 8'hff)
        drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.s_ready  = s_ready_c;
  assign bus.drop_cnt = drop_q;

  always_comb begin
    bus.m_valid = '0;
    bus.m_last  = '0;
    bus.m_data  = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (full && out_dst == SEL_W'(k)) begin
        bus.m_valid[k]              = 1'b1;
        bus.m_last[k]               = last_q;
        bus.m_data[k*WIDTH +: WIDTH] = data_q;
      end
    end
  end
endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: routing, backpressure, reset,
// drop counting/saturation and lane isolation across three configs.
module tb_stream_demux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(8),  .N_OUT(4), .SEL_W(2)) ia ();
  stream_demux_if #(.WIDTH(8),  .N_OUT(3), .SEL_W(2)) ib ();
  stream_demux_if #(.WIDTH(16), .N_OUT(8), .SEL_W(3)) ic ();

  stream_demux #(.WIDTH(8),  .N_OUT(4), .SEL_W(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ia));
  stream_demux #(.WIDTH(8),  .N_OUT(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ib));
  stream_demux #(.WIDTH(16), .N_OUT(8), .SEL_W(3)) dut_c (
    .clk(clk), .rst(rst), .bus(ic));

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [7:0]  d;
    logic        l;
    logic [3:0]  rdy;
    logic        x_srdy;
    logic [3:0]  x_mv;
    logic [31:0] x_md;
    logic [3:0]  x_ml;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(
    input logic v, input logic [1:0] sel, input logic [7:0] d,
    input logic l, input logic [3:0] rdy, input logic x_srdy,
    input logic [3:0] x_mv, input logic [31:0] x_md,
    input logic [3:0] x_ml);
    vec_t r;
    r.v = v; r.sel = sel; r.d = d; r.l = l; r.rdy = rdy;
    r.x_srdy = x_srdy; r.x_mv = x_mv; r.x_md = x_md; r.x_ml = x_ml;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ia.s_valid = 0; ia.s_sel = 0; ia.s_data = 0; ia.s_last = 0;
    ia.m_ready = 4'hf;
    ib.s_valid = 0; ib.s_sel = 0; ib.s_data = 0; ib.s_last = 0;
    ib.m_ready = 3'b111;
    ic.s_valid = 0; ic.s_sel = 0; ic.s_data = 0; ic.s_last = 0;
    ic.m_ready = 8'hff;

    // routing, packet boundary without bubble, then ch1 stall
    tbl[0]  = mk(1, 2, 8'h11, 0, 4'hf, 1, 4'h0, 32'h0,        4'h0);
    tbl[1]  = mk(1, 1, 8'h12, 0, 4'hf, 1, 4'h4, 32'h00110000, 4'h0);
    tbl[2]  = mk(1, 3, 8'h13, 1, 4'hf, 1, 4'h4, 32'h00120000, 4'h0);
    tbl[3]  = mk(1, 0, 8'h21, 0, 4'hf, 1, 4'h4, 32'h00130000, 4'h4);
    tbl[4]  = mk(1, 2, 8'h22, 1, 4'hf, 1, 4'h1, 32'h00000021, 4'h0);
    tbl[5]  = mk(0, 0, 8'h00, 0, 4'hf, 1, 4'h1, 32'h00000022, 4'h1);
    tbl[6]  = mk(0, 0, 8'h00, 0, 4'hf, 1, 4'h0, 32'h0,        4'h0);
    tbl[7]  = mk(1, 1, 8'h31, 0, 4'hf, 1, 4'h0, 32'h0,        4'h0);
    tbl[8]  = mk(1, 1, 8'h32, 0, 4'hd, 0, 4'h2, 32'h00003100, 4'h0);
    tbl[9]  = mk(1, 1, 8'h32, 0, 4'hd, 0, 4'h2, 32'h00003100, 4'h0);
    tbl[10] = mk(1, 1, 8'h32, 0, 4'hd, 0, 4'h2, 32'h00003100, 4'h0);
    tbl[11] = mk(1, 1, 8'h32, 0, 4'hd, 0, 4'h2, 32'h00003100, 4'h0);
    tbl[12] = mk(1, 1, 8'h32, 0, 4'hf, 1, 4'h2, 32'h00003100, 4'h0);
    tbl[13] = mk(1, 0, 8'h33, 1, 4'hf, 1, 4'h2, 32'h00003200, 4'h0);
    tbl[14] = mk(0, 0, 8'h00, 0, 4'hf, 1, 4'h2, 32'h00003300, 4'h2);
    tbl[15] = mk(0, 0, 8'h00, 0, 4'hf, 1, 4'h0, 32'h0,        4'h0);

    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_a_srdy", 128'(ia.s_ready), 128'(1'b1));
    chk("rst_a_mv",   128'(ia.m_valid), 128'(4'h0));
    chk("rst_a_md",   128'(ia.m_data),  128'(32'h0));
    chk("rst_a_drop", 128'(ia.drop_cnt), 128'(8'h0));
    chk("rst_b_mv",   128'(ib.m_valid), 128'(3'b000));
    chk("rst_c_mv",   128'(ic.m_valid), 128'(8'h00));

    for (int i = 0; i < 16; i++) begin
      ia.s_valid = tbl[i].v;
      ia.s_sel   = tbl[i].sel;
      ia.s_data  = tbl[i].d;
      ia.s_last  = tbl[i].l;
      ia.m_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_srdy", i), 128'(ia.s_ready), 128'(tbl[i].x_srdy));
      chk($sformatf("v%0d_mv", i),   128'(ia.m_valid), 128'(tbl[i].x_mv));
      chk($sformatf("v%0d_md", i),   128'(ia.m_data),  128'(tbl[i].x_md));
      chk($sformatf("v%0d_ml", i),   128'(ia.m_last),  128'(tbl[i].x_ml));
      tick();
    end

    // reset mid-packet with a held beat; next beat is a first beat
    ia.s_valid = 1; ia.s_sel = 1; ia.s_data = 8'h41; ia.s_last = 0;
    ia.m_ready = 4'h0;
    tick();
    ia.s_data = 8'h42;
    #1;
    chk("pre_rst_mv", 128'(ia.m_valid), 128'(4'h2));
    rst = 1;
    tick();
    tick();
    rst = 0;
    ia.s_sel = 3; ia.s_data = 8'h51; ia.s_last = 1; ia.m_ready = 4'hf;
    #1;
    chk("mid_rst_mv",   128'(ia.m_valid),  128'(4'h0));
    chk("mid_rst_md",   128'(ia.m_data),   128'(32'h0));
    chk("mid_rst_drop", 128'(ia.drop_cnt), 128'(8'h0));
    chk("mid_rst_srdy", 128'(ia.s_ready),  128'(1'b1));
    tick();
    ia.s_valid = 0;
    #1;
    chk("post_rst_mv", 128'(ia.m_valid), 128'(4'h8));
    chk("post_rst_md", 128'(ia.m_data),  128'(32'h51000000));
    chk("post_rst_ml", 128'(ia.m_last),  128'(4'h8));
    tick();
    chk("post_rst_idle", 128'(ia.m_valid), 128'(4'h0));

    // 4-beat packet to nonexistent channel 3 on a 3-channel demux
    for (int b = 0; b < 4; b++) begin
      ib.s_valid = 1;
      ib.s_sel   = (b == 2) ? 2'd0 : 2'd3;
      ib.s_data  = 8'(8'h70 + b);
      ib.s_last  = (b == 3);
      #1;
      chk($sformatf("drop_b%0d_srdy", b), 128'(ib.s_ready), 128'(1'b1));
      chk($sformatf("drop_b%0d_mv", b),   128'(ib.m_valid), 128'(3'b000));
      tick();
    end
    ib.s_valid = 0;
    #1;
    chk("drop_mv",  128'(ib.m_valid),  128'(3'b000));
    chk("drop_cnt", 128'(ib.drop_cnt), 128'(8'd1));

    ib.s_valid = 1; ib.s_sel = 1; ib.s_data = 8'h61; ib.s_last = 0;
    tick();
    ib.s_data = 8'h62; ib.s_last = 1; ib.s_sel = 2;
    #1;
    chk("after_drop_mv1", 128'(ib.m_valid), 128'(3'b010));
    chk("after_drop_md1", 128'(ib.m_data),  128'(24'h006100));
    tick();
    ib.s_valid = 0;
    #1;
    chk("after_drop_mv2", 128'(ib.m_valid), 128'(3'b010));
    chk("after_drop_md2", 128'(ib.m_data),  128'(24'h006200));
    chk("after_drop_ml2", 128'(ib.m_last),  128'(3'b010));

    // saturation: 254 more drops reach 255, six more must not wrap
    for (int p = 0; p < 254; p++) begin
      ib.s_valid = 1; ib.s_sel = 3; ib.s_last = 1; ib.s_data = 8'(p);
      tick();
    end
    ib.s_valid = 0;
    #1;
    chk("sat_255", 128'(ib.drop_cnt), 128'(8'd255));
    for (int p = 0; p < 6; p++) begin
      ib.s_valid = 1; ib.s_sel = 3; ib.s_last = 1;
      tick();
    end
    ib.s_valid = 0;
    #1;
    chk("sat_hold", 128'(ib.drop_cnt), 128'(8'd255));
    chk("sat_mv",   128'(ib.m_valid),  128'(3'b000));

    // lane isolation on a wide 8-channel config
    ic.s_valid = 1; ic.s_sel = 7; ic.s_data = 16'hBEEF; ic.s_last = 1;
    tick();
    ic.s_sel = 0; ic.s_data = 16'h1234;
    #1;
    chk("lane7_md", 128'(ic.m_data),  {16'hBEEF, 112'h0});
    chk("lane7_mv", 128'(ic.m_valid), 128'(8'h80));
    chk("lane7_ml", 128'(ic.m_last),  128'(8'h80));
    tick();
    ic.s_valid = 0;
    #1;
    chk("lane0_md", 128'(ic.m_data),  128'(16'h1234));
    chk("lane0_mv", 128'(ic.m_valid), 128'(8'h01));
    tick();
    chk("lane_idle", 128'(ic.m_data), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
